// File: rtl/tep_intc.sv
// tep_intc: fixed-priority interrupt controller (interval timer + three edge-triggered lines).
// Define TEP_INTC_NESTING_EN to allow higher-priority sources to preempt an active service.
module tep_intc #(
    parameter logic [15:0] VECTOR_BASE   = 16'h0010,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0004,
    parameter logic [15:0] INTERVAL_RST  = 16'hfffc
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic [2:0]  irq_in,
    input  logic        cpu_eint,
    input  logic        cpu_dint,
    input  logic        cpu_rint,
    input  logic        cpu_ack,
    output logic        int_req,
    output logic [15:0] int_vector,
    input  logic        reg_sel,
    input  logic        reg_we,
    input  logic [1:0]  reg_adrs,
    input  logic [15:0] reg_wdata,
    output logic [15:0] reg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  irq_prev_q, irq_prev_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  in_service_q, in_service_d;
    logic        ie_q, ie_d;
    logic [1:0]  id_q, id_d;
    logic [15:0] vector_q, vector_d;
    logic [15:0] interval_q, interval_d;
    logic [15:0] counter_q, counter_d;
    logic [15:0] rdata_q, rdata_d;

    logic        reg_wr, reg_rd, tick, ack_take, cand_valid, seen;
    logic [3:0]  events, clr, elig, elig_serv, avail, pop, in_service_left;
    logic [1:0]  cand_id;
    logic [15:0] vector_calc, status;

    // Handshake: int_req rises with int_vector valid and both stay frozen until the
    // cycle cpu_ack is sampled high in REQ; cpu_ack in any other state is ignored.
    always_comb begin
        reg_wr = reg_sel & reg_we;
        reg_rd = reg_sel & ~reg_we;
        tick   = (counter_q == 16'd1);
        events = {irq_in & ~irq_prev_q, tick};
        irq_prev_d = irq_in;

        interval_d = interval_q;
        if (reg_wr && reg_adrs == 2'd0) begin
            interval_d = reg_wdata;
            counter_d  = reg_wdata;
        end else if (interval_q == 16'd0) begin
            counter_d = 16'd0;
        end else if (counter_q <= 16'd1) begin
            counter_d = interval_q;
        end else begin
            counter_d = counter_q - 16'd1;
        end

        mask_d = mask_q;
        if (reg_wr && reg_adrs == 2'd1) begin
            mask_d = reg_wdata[3:0];
        end

        // Bits strictly above the highest-priority in-service source may preempt it.
        seen      = 1'b0;
        elig_serv = 4'd0;
        for (int i = 0; i < 4; i++) begin
            seen         = seen | in_service_q[i];
            elig_serv[i] = ~seen;
        end

        elig = 4'd0;
        if (state_q == ST_IDLE) begin
            elig = 4'hf;
        end
`ifdef TEP_INTC_NESTING_EN
        if (state_q == ST_SERV) begin
            elig = elig_serv;
        end
`endif

        avail      = pending_q & mask_q & elig;
        cand_valid = ie_q & (|avail);
        cand_id    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (avail[i]) begin
                cand_id = 2'(i);
            end
        end
        vector_calc = VECTOR_BASE + VECTOR_STRIDE * {14'd0, cand_id};

        pop             = cpu_rint ? (in_service_q & (~in_service_q + 4'd1)) : 4'd0;
        in_service_left = in_service_q & ~pop;

        state_d  = state_q;
        id_d     = id_q;
        vector_d = vector_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cand_valid) begin
                    state_d  = ST_REQ;
                    id_d     = cand_id;
                    vector_d = vector_calc;
                end
            end
            ST_REQ: begin
                if (cpu_ack) begin
                    ack_take = 1'b1;
                    state_d  = ST_SERV;
                end
            end
            ST_SERV: begin
                if (cpu_rint) begin
                    if (in_service_left == 4'd0) begin
                        state_d = ST_IDLE;
                    end
                end else if (cand_valid) begin
                    state_d  = ST_REQ;
                    id_d     = cand_id;
                    vector_d = vector_calc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_service_d = in_service_left;
        if (ack_take) begin
            in_service_d = in_service_left | (4'b0001 << id_q);
        end

        // A new event on a bit overrides any clear of that bit in the same cycle.
        clr = 4'd0;
        if (reg_wr && reg_adrs == 2'd2) begin
            clr = reg_wdata[3:0];
        end
        if (ack_take) begin
            clr = clr | (4'b0001 << id_q);
        end
        pending_d = (pending_q & ~clr) | events;

        ie_d = ie_q;
        if (cpu_eint || cpu_rint) begin
            ie_d = 1'b1;
        end
        if (cpu_dint || ack_take) begin
            ie_d = 1'b0;
        end

        status  = {7'd0, ie_q, in_service_q, 2'b00, state_q};
        rdata_d = rdata_q;
        if (reg_rd) begin
            case (reg_adrs)
                2'd0:    rdata_d = interval_q;
                2'd1:    rdata_d = {12'd0, mask_q};
                2'd2:    rdata_d = {12'd0, pending_q};
                default: rdata_d = status;
            endcase
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q      <= ST_IDLE;
            irq_prev_q   <= 3'd0;
            pending_q    <= 4'd0;
            mask_q       <= 4'd0;
            in_service_q <= 4'd0;
            ie_q         <= 1'b0;
            id_q         <= 2'd0;
            vector_q     <= VECTOR_BASE;
            interval_q   <= INTERVAL_RST;
            counter_q    <= INTERVAL_RST;
            rdata_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            ie_q         <= ie_d;
            id_q         <= id_d;
            vector_q     <= vector_d;
            interval_q   <= interval_d;
            counter_q    <= counter_d;
            rdata_q      <= rdata_d;
        end
    end

    assign int_req    = (state_q == ST_REQ);
    assign int_vector = vector_q;
    assign reg_rdata  = rdata_q;

endmodule

// File: tb/tb_tep_intc.sv
// Directed bench for tep_intc; expected values are hand-computed per scenario.
module tb_tep_intc;

    logic        m_clock = 1'b0;
    logic        p_reset = 1'b0;
    logic [2:0]  irq_in = 3'd0;
    logic        cpu_eint = 1'b0;
    logic        cpu_dint = 1'b0;
    logic        cpu_rint = 1'b0;
    logic        cpu_ack = 1'b0;
    logic        int_req;
    logic [15:0] int_vector;
    logic        reg_sel = 1'b0;
    logic        reg_we = 1'b0;
    logic [1:0]  reg_adrs = 2'd0;
    logic [15:0] reg_wdata = 16'd0;
    logic [15:0] reg_rdata;

    int n_checks = 0;
    int n_fail = 0;

    tep_intc dut (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .irq_in     (irq_in),
        .cpu_eint   (cpu_eint),
        .cpu_dint   (cpu_dint),
        .cpu_rint   (cpu_rint),
        .cpu_ack    (cpu_ack),
        .int_req    (int_req),
        .int_vector (int_vector),
        .reg_sel    (reg_sel),
        .reg_we     (reg_we),
        .reg_adrs   (reg_adrs),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata)
    );

    always #5 m_clock = ~m_clock;

    // Every driver task returns 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge m_clock);
            #1;
        end
    endtask

    task automatic do_reset();
        p_reset = 1'b1;
        irq_in = 3'd0;
        cpu_eint = 1'b0;
        cpu_dint = 1'b0;
        cpu_rint = 1'b0;
        cpu_ack = 1'b0;
        reg_sel = 1'b0;
        reg_we = 1'b0;
        step(2);
        p_reset = 1'b0;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        reg_sel = 1'b1;
        reg_we = 1'b1;
        reg_adrs = a;
        reg_wdata = d;
        step(1);
        reg_sel = 1'b0;
        reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [15:0] d);
        reg_sel = 1'b1;
        reg_we = 1'b0;
        reg_adrs = a;
        step(1);
        reg_sel = 1'b0;
        d = reg_rdata;
    endtask

    task automatic pulse_eint();
        cpu_eint = 1'b1; step(1); cpu_eint = 1'b0;
    endtask

    task automatic pulse_dint();
        cpu_dint = 1'b1; step(1); cpu_dint = 1'b0;
    endtask

    task automatic pulse_rint();
        cpu_rint = 1'b1; step(1); cpu_rint = 1'b0;
    endtask

    task automatic pulse_ack();
        cpu_ack = 1'b1; step(1); cpu_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        do_reset();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req: got %b expected 0", int_req); end
        n_checks++; if (int_vector !== 16'h0010) begin n_fail++; $display("FAIL reset_vector: got %h expected 0010", int_vector); end
        n_checks++; if (reg_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", reg_rdata); end
        reg_read(2'd0, d);
        n_checks++; if (d !== 16'hfffc) begin n_fail++; $display("FAIL reset_interval: got %h expected fffc", d); end
        reg_read(2'd1, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_mask: got %h expected 0000", d); end
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_status: got %h expected 0000", d); end
    endtask

    task automatic test_timer();
        logic [15:0] d;
        do_reset();
        reg_write(2'd0, 16'h0008);
        reg_write(2'd1, 16'h0001);
        step(6);
        reg_read(2'd2, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL timer_before_tick1: got %h expected 0000", d); end
        reg_read(2'd2, d);
        n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL timer_tick1: got %h expected 0001", d); end
        reg_write(2'd2, 16'h0001);
        step(5);
        reg_read(2'd2, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL timer_before_tick2: got %h expected 0000", d); end
        reg_read(2'd2, d);
        n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL timer_tick2: got %h expected 0001", d); end
        pulse_eint();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL timer_req_at_eint: got %b expected 0", int_req); end
        step(1);
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL timer_req: got %b expected 1", int_req); end
        n_checks++; if (int_vector !== 16'h0010) begin n_fail++; $display("FAIL timer_vector: got %h expected 0010", int_vector); end
        pulse_ack();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL timer_req_after_ack: got %b expected 0", int_req); end
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0012) begin n_fail++; $display("FAIL timer_status_serv: got %h expected 0012", d); end
        reg_write(2'd0, 16'h0000);
        pulse_rint();
        step(2);
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL timer_stopped_req: got %b expected 0", int_req); end
        reg_read(2'd2, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL timer_stopped_pending: got %h expected 0000", d); end
    endtask

    task automatic test_priority();
        logic [15:0] d;
        do_reset();
        reg_write(2'd1, 16'h000e);
        pulse_eint();
        irq_in = 3'b110;
        step(1);
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL prio_req_at_edge: got %b expected 0", int_req); end
        step(1);
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL prio_req_first: got %b expected 1", int_req); end
        n_checks++; if (int_vector !== 16'h0018) begin n_fail++; $display("FAIL prio_vector_first: got %h expected 0018", int_vector); end
        pulse_ack();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL prio_req_after_ack: got %b expected 0", int_req); end
        pulse_rint();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL prio_req_at_rint: got %b expected 0", int_req); end
        step(1);
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL prio_req_second: got %b expected 1", int_req); end
        n_checks++; if (int_vector !== 16'h001c) begin n_fail++; $display("FAIL prio_vector_second: got %h expected 001c", int_vector); end
        pulse_ack();
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0082) begin n_fail++; $display("FAIL prio_status: got %h expected 0082", d); end
        pulse_rint();
        irq_in = 3'b000;
    endtask

    task automatic test_ie_gate();
        logic [15:0] d;
        do_reset();
        reg_write(2'd1, 16'h0002);
        irq_in = 3'b001;
        step(3);
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL gate_req_ie0: got %b expected 0", int_req); end
        pulse_ack();
        reg_read(2'd2, d);
        n_checks++; if (d !== 16'h0002) begin n_fail++; $display("FAIL gate_pending_after_stray_ack: got %h expected 0002", d); end
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL gate_status_idle: got %h expected 0000", d); end
        pulse_eint();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL gate_req_at_eint: got %b expected 0", int_req); end
        step(1);
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL gate_req: got %b expected 1", int_req); end
        n_checks++; if (int_vector !== 16'h0014) begin n_fail++; $display("FAIL gate_vector: got %h expected 0014", int_vector); end
        reg_write(2'd1, 16'h0000);
        pulse_dint();
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL gate_req_held: got %b expected 1", int_req); end
        n_checks++; if (int_vector !== 16'h0014) begin n_fail++; $display("FAIL gate_vector_held: got %h expected 0014", int_vector); end
        pulse_ack();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL gate_req_after_ack: got %b expected 0", int_req); end
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0022) begin n_fail++; $display("FAIL gate_status_serv: got %h expected 0022", d); end
        pulse_rint();
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0100) begin n_fail++; $display("FAIL gate_status_after_rint: got %h expected 0100", d); end
        irq_in = 3'b000;
    endtask

    task automatic test_rint_idle();
        logic [15:0] d;
        do_reset();
        pulse_rint();
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0100) begin n_fail++; $display("FAIL rint_idle_status: got %h expected 0100", d); end
    endtask

    task automatic test_set_wins();
        logic [15:0] d;
        do_reset();
        irq_in = 3'b010;
        step(1);
        irq_in = 3'b000;
        step(1);
        irq_in = 3'b001;
        reg_write(2'd2, 16'h0006);
        irq_in = 3'b000;
        reg_read(2'd2, d);
        n_checks++; if (d !== 16'h0002) begin n_fail++; $display("FAIL set_wins_pending: got %h expected 0002", d); end
    endtask

    task automatic test_nesting();
        logic [15:0] d;
        do_reset();
        reg_write(2'd1, 16'h000a);
        pulse_eint();
        irq_in = 3'b100;
        step(2);
        n_checks++; if (int_vector !== 16'h001c) begin n_fail++; $display("FAIL nest_vector_src3: got %h expected 001c", int_vector); end
        pulse_ack();
        irq_in = 3'b101;
        step(3);
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_req_ie0: got %b expected 0", int_req); end
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0082) begin n_fail++; $display("FAIL nest_status_src3: got %h expected 0082", d); end
        pulse_eint();
        step(1);
`ifdef TEP_INTC_NESTING_EN
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL nest_preempt_req: got %b expected 1", int_req); end
        n_checks++; if (int_vector !== 16'h0014) begin n_fail++; $display("FAIL nest_preempt_vector: got %h expected 0014", int_vector); end
        pulse_ack();
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h00a2) begin n_fail++; $display("FAIL nest_status_both: got %h expected 00a2", d); end
        pulse_rint();
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0182) begin n_fail++; $display("FAIL nest_status_pop1: got %h expected 0182", d); end
        pulse_rint();
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0100) begin n_fail++; $display("FAIL nest_status_pop2: got %h expected 0100", d); end
`else
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_no_preempt: got %b expected 0", int_req); end
        pulse_rint();
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_req_at_rint: got %b expected 0", int_req); end
        step(1);
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL nest_req_after_rint: got %b expected 1", int_req); end
        n_checks++; if (int_vector !== 16'h0014) begin n_fail++; $display("FAIL nest_vector_after_rint: got %h expected 0014", int_vector); end
        pulse_ack();
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0022) begin n_fail++; $display("FAIL nest_status_src1: got %h expected 0022", d); end
`endif
        irq_in = 3'b000;
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        do_reset();
        reg_write(2'd1, 16'h0002);
        reg_write(2'd0, 16'h0020);
        pulse_eint();
        irq_in = 3'b001;
        step(2);
        n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_before_reset: got %b expected 1", int_req); end
        reg_read(2'd1, d);
        p_reset = 1'b1;
        irq_in = 3'b000;
        step(1);
        p_reset = 1'b0;
        n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL mid_req_after_reset: got %b expected 0", int_req); end
        n_checks++; if (int_vector !== 16'h0010) begin n_fail++; $display("FAIL mid_vector_after_reset: got %h expected 0010", int_vector); end
        n_checks++; if (reg_rdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rdata_after_reset: got %h expected 0000", reg_rdata); end
        reg_read(2'd3, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL mid_status: got %h expected 0000", d); end
        reg_read(2'd0, d);
        n_checks++; if (d !== 16'hfffc) begin n_fail++; $display("FAIL mid_interval: got %h expected fffc", d); end
        reg_read(2'd1, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL mid_mask: got %h expected 0000", d); end
        reg_read(2'd2, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL mid_pending: got %h expected 0000", d); end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_priority();
        test_ie_gate();
        test_rint_idle();
        test_set_wins();
        test_nesting();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
